// File: rtl/tdes_pass_sequencer.sv
// Triple-DES pass sequencer: runs a single-DES core three times (EDE or DED)
// with the correct key and direction per pass, chaining each result into the next pass.
module tdes_pass_sequencer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        enable,
    input  logic        encryptionType,
    input  logic [63:0] data,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic        desStart,
    output logic        desDecrypt,
    output logic [63:0] desKey,
    output logic [63:0] desData,
    input  logic        desDone,
    input  logic [63:0] desResult,
    output logic        busy,
    output logic        outputEnable,
    output logic [63:0] outputData,
    output logic        error,
    output logic        overrun
);

    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    pass_q;
    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_nxt;
    logic          enc_q;
    logic [63:0]   k1_q, k2_q, k3_q;
    logic          accept, capture, tmo;

    // Pass 1 always uses key2; the outer passes use key1/key3, swapped for decryption.
    function automatic logic [63:0] pass_key(input logic enc, input logic [1:0] p,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        if (p == 2'd1)
            return b;
        else if ((p == 2'd0) == enc)
            return a;
        else
            return c;
    endfunction

    assign tcnt_nxt = tcnt_q + 1'b1;
    assign desStart = (state_q == ISSUE);
    assign busy     = (state_q == ISSUE) || (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (enable) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (desDone) begin
                    capture = 1'b1;
                    state_d = (pass_q == 2'd2) ? DONE : ISSUE;
                end else if (tcnt_nxt == TW'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q      <= IDLE;
            pass_q       <= '0;
            tcnt_q       <= '0;
            enc_q        <= 1'b0;
            k1_q         <= '0;
            k2_q         <= '0;
            k3_q         <= '0;
            desDecrypt   <= 1'b0;
            desKey       <= '0;
            desData      <= '0;
            outputEnable <= 1'b0;
            outputData   <= '0;
            error        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                enc_q        <= encryptionType;
                k1_q         <= key1;
                k2_q         <= key2;
                k3_q         <= key3;
                pass_q       <= '0;
                tcnt_q       <= '0;
                outputEnable <= 1'b0;
                outputData   <= '0;
                error        <= 1'b0;
                overrun      <= 1'b0;
                desData      <= data;
                desDecrypt   <= ~encryptionType;
                desKey       <= pass_key(encryptionType, 2'd0, key1, key2, key3);
            end else if (busy && enable) begin
                overrun <= 1'b1;
            end

            if (state_q == ISSUE)
                tcnt_q <= '0;

            // desData doubles as the capture register for the chained result.
            if (capture) begin
                if (pass_q != 2'd2) begin
                    pass_q     <= pass_q + 2'd1;
                    desData    <= desResult;
                    desDecrypt <= enc_q ^ ((pass_q + 2'd1) != 2'd1);
                    desKey     <= pass_key(enc_q, pass_q + 2'd1, k1_q, k2_q, k3_q);
                end else begin
                    outputData   <= desResult;
                    outputEnable <= 1'b1;
                end
            end else if (state_q == WAIT) begin
                tcnt_q <= tcnt_nxt;
            end

            if (tmo)
                error <= 1'b1;
        end
    end

endmodule
